// File: rtl/ddr_pkg.sv
// Shared types for the DDR game controller: FSM states and the arrow bundle layout.
// Arrow bundles are always {left,right,up,down}, i.e. bit LEFT is the MSB.
package ddr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_PLAY,
    S_CHECK,
    S_WIN,
    S_LOSE
  } state_t;

  localparam int ARROW_W = 4;
  localparam int LEFT    = 3;
  localparam int RIGHT   = 2;
  localparam int UP      = 1;
  localparam int DOWN    = 0;

  typedef logic [ARROW_W-1:0] arrow_t;

  function automatic arrow_t arrow_bit(input int idx);
    return arrow_t'(1) << idx;
  endfunction

endpackage

// File: rtl/ddr_hit_judge.sv
// Judges player presses against the displayed arrow: edge-detects buttons, arms on a
// new arrow, and emits a one-cycle hit when the first press inside the window matches.
module ddr_hit_judge
  import ddr_pkg::*;
#(
  parameter int HIT_WIN = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               active,
  input  logic [ARROW_W-1:0] btn,
  input  logic [ARROW_W-1:0] arrows,
  output logic               hit,
  output logic               armed
);

  localparam int CNT_W = $clog2(HIT_WIN + 1);
  localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(HIT_WIN);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(1);

  logic [ARROW_W-1:0] btn_q;
  logic [ARROW_W-1:0] arrows_q;
  logic [ARROW_W-1:0] expected;
  logic [CNT_W-1:0]   window;
  logic [ARROW_W-1:0] rise;
  logic               press;
  logic               arrow_event;

  assign rise        = btn & ~btn_q;
  assign press       = |rise;
  assign arrow_event = active && (arrows != '0) && (arrows != arrows_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q    <= btn;
      arrows_q <= '0;
      expected <= '0;
      window   <= '0;
      armed    <= 1'b0;
      hit      <= 1'b0;
    end else begin
      btn_q    <= btn;
      arrows_q <= arrows;
      hit      <= 1'b0;
      if (!active) begin
        armed <= 1'b0;
      end else begin
        // The press is settled against the old arrow before a new arrow re-arms.
        if (armed && press) begin
          hit   <= (rise == expected);
          armed <= 1'b0;
        end else if (armed) begin
          window <= window - WIN_LAST;
          if (window == WIN_LAST) armed <= 1'b0;
        end
        if (arrow_event) begin
          armed    <= 1'b1;
          expected <= arrows;
          window   <= WIN_LOAD;
        end
      end
    end
  end

endmodule

// File: rtl/ddr_level_sequencer.sv
// DDR game controller: launches each level generator in turn, shows its arrows,
// counts judged hits per level and in total, and ends the game in WIN or LOSE.
module ddr_level_sequencer
  import ddr_pkg::*;
#(
  parameter int NUM_LEVELS = 4,
  parameter int SCORE_W    = 8,
  parameter int PASS_HITS  = 10,
  parameter int HIT_WIN    = 200
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_btn,
  input  logic [3:0]                      btn,
  input  logic [4*NUM_LEVELS-1:0]         lvl_arrows,
  input  logic [NUM_LEVELS-1:0]           lvl_done,
  output logic [NUM_LEVELS-1:0]           lvl_start,
  output logic [3:0]                      arrows,
  output logic [$clog2(NUM_LEVELS)-1:0]   level,
  output logic [SCORE_W-1:0]              score,
  output logic                            playing,
  output logic                            game_win,
  output logic                            game_over
);

  localparam int LEVEL_W = $clog2(NUM_LEVELS);
  localparam logic [LEVEL_W-1:0]    LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [LEVEL_W-1:0]    LEVEL_ONE  = LEVEL_W'(1);
  localparam logic [SCORE_W-1:0]    PASS_C     = SCORE_W'(PASS_HITS);
  localparam logic [SCORE_W-1:0]    SCORE_ONE  = SCORE_W'(1);
  localparam logic [NUM_LEVELS-1:0] START_ONE  = NUM_LEVELS'(1);

  state_t             state;
  logic [SCORE_W-1:0] lvl_hits;
  logic               start_q;
  logic               start_edge;
  logic               hit;
  logic               armed_unused;
  logic [ARROW_W-1:0] lvl_arrow_arr [NUM_LEVELS];

  for (genvar gi = 0; gi < NUM_LEVELS; gi++) begin : g_unpack
    assign lvl_arrow_arr[gi] = lvl_arrows[ARROW_W*gi +: ARROW_W];
  end

  ddr_hit_judge #(
    .HIT_WIN (HIT_WIN)
  ) u_judge (
    .clk    (clk),
    .rst    (rst),
    .active (state == S_PLAY),
    .btn    (btn),
    .arrows (arrows),
    .hit    (hit),
    .armed  (armed_unused)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lvl_start  <= '0;
      arrows     <= '0;
      level      <= '0;
      score      <= '0;
      lvl_hits   <= '0;
      playing    <= 1'b0;
      game_win   <= 1'b0;
      game_over  <= 1'b0;
      start_q    <= start_btn;
      start_edge <= 1'b0;
    end else begin
      start_q    <= start_btn;
      start_edge <= start_btn & ~start_q;
      lvl_start  <= '0;
      // A hit can land one cycle after PLAY ends; counter clears below take priority.
      if (hit) begin
        if (score != '1)    score    <= score + SCORE_ONE;
        if (lvl_hits != '1) lvl_hits <= lvl_hits + SCORE_ONE;
      end
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          arrows <= '0;
          if (start_edge) begin
            score     <= '0;
            level     <= '0;
            lvl_hits  <= '0;
            lvl_start <= START_ONE;
            game_win  <= 1'b0;
            game_over <= 1'b0;
            state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          arrows  <= '0;
          playing <= 1'b1;
          state   <= S_PLAY;
        end
        S_PLAY: begin
          if (lvl_done[level]) begin
            arrows  <= '0;
            playing <= 1'b0;
            state   <= S_CHECK;
          end else begin
            arrows <= lvl_arrow_arr[level];
          end
        end
        S_CHECK: begin
          arrows <= '0;
          if (lvl_hits >= PASS_C) begin
            if (level == LAST_LEVEL) begin
              game_win <= 1'b1;
              state    <= S_WIN;
            end else begin
              level     <= level + LEVEL_ONE;
              lvl_hits  <= '0;
              lvl_start <= START_ONE << (level + LEVEL_ONE);
              state     <= S_LAUNCH;
            end
          end else begin
            game_over <= 1'b1;
            state     <= S_LOSE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_level_sequencer.sv
// Directed bench for ddr_level_sequencer: a cycle-level game model checks every output
// each cycle, and literal checkpoints pin the model at the key moments of each game.
module tb_ddr_level_sequencer;

  localparam int NL = 4;
  localparam int SW = 8;
  localparam int PH = 10;
  localparam int HW = 200;

  localparam int P_IDLE = 0, P_LAUNCH = 1, P_PLAY = 2, P_CHECK = 3, P_WIN = 4, P_LOSE = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_btn = 1'b0;
  logic [3:0]    btn = 4'b0;
  logic [4*NL-1:0] lvl_arrows = '0;
  logic [NL-1:0] lvl_done = '0;
  logic [NL-1:0] lvl_start;
  logic [3:0]    arrows;
  logic [1:0]    level;
  logic [SW-1:0] score;
  logic          playing;
  logic          game_win;
  logic          game_over;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  ddr_level_sequencer #(
    .NUM_LEVELS (NL),
    .SCORE_W    (SW),
    .PASS_HITS  (PH),
    .HIT_WIN    (HW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_btn  (start_btn),
    .btn        (btn),
    .lvl_arrows (lvl_arrows),
    .lvl_done   (lvl_done),
    .lvl_start  (lvl_start),
    .arrows     (arrows),
    .level      (level),
    .score      (score),
    .playing    (playing),
    .game_win   (game_win),
    .game_over  (game_over)
  );

  // Game model: phase, counters and a timestamped judge (armed arrow + cycle it appeared).
  int         cyc = 0;
  int         m_phase = P_IDLE;
  int         m_level = 0;
  int         m_score = 0;
  int         m_hits = 0;
  int         m_arm_cyc = 0;
  int         old_hits;
  logic [3:0] m_arrows = 4'b0;
  logic [3:0] m_prev_arrows = 4'b0;
  logic [3:0] m_exp = 4'b0;
  logic [3:0] m_prev_btn = 4'b0;
  logic [3:0] rise;
  bit         m_armed = 1'b0;
  bit         m_hit_pipe = 1'b0;
  bit         new_hit;
  bit         m_start_pend = 1'b0;
  bit         m_prev_start = 1'b0;
  bit         start_now;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_phase       = P_IDLE;
      m_level       = 0;
      m_score       = 0;
      m_hits        = 0;
      m_arrows      = 4'b0;
      m_prev_arrows = 4'b0;
      m_armed       = 1'b0;
      m_hit_pipe    = 1'b0;
      m_start_pend  = 1'b0;
      m_prev_btn    = btn;
      m_prev_start  = start_btn;
    end else begin
      rise    = btn & ~m_prev_btn;
      new_hit = 1'b0;
      if (m_phase == P_PLAY) begin
        if (rise != 4'b0 && m_armed) begin
          if ((cyc - m_arm_cyc) <= HW && rise == m_exp) new_hit = 1'b1;
          m_armed = 1'b0;
        end
        if (m_arrows != 4'b0 && m_arrows != m_prev_arrows) begin
          m_armed   = 1'b1;
          m_exp     = m_arrows;
          m_arm_cyc = cyc;
        end
      end else begin
        m_armed = 1'b0;
      end
      m_prev_arrows = m_arrows;
      m_prev_btn    = btn;

      old_hits = m_hits;
      if (m_hit_pipe) begin
        if (m_score < 255) m_score++;
        if (m_hits < 255)  m_hits++;
      end
      m_hit_pipe = new_hit;

      start_now    = m_start_pend;
      m_start_pend = start_btn && !m_prev_start;
      m_prev_start = start_btn;

      case (m_phase)
        P_LAUNCH: begin
          m_arrows = 4'b0;
          m_phase  = P_PLAY;
        end
        P_PLAY: begin
          if (lvl_done[m_level]) begin
            m_arrows = 4'b0;
            m_phase  = P_CHECK;
          end else begin
            m_arrows = lvl_arrows[4*m_level +: 4];
          end
        end
        P_CHECK: begin
          m_arrows = 4'b0;
          if (old_hits >= PH) begin
            if (m_level == NL - 1) m_phase = P_WIN;
            else begin
              m_level++;
              m_hits  = 0;
              m_phase = P_LAUNCH;
            end
          end else m_phase = P_LOSE;
        end
        default: begin
          m_arrows = 4'b0;
          if (start_now) begin
            m_score = 0;
            m_level = 0;
            m_hits  = 0;
            m_phase = P_LAUNCH;
          end
        end
      endcase
    end
  end

  logic [20:0] act_vec;
  logic [20:0] req_vec;

  always @(negedge clk) begin
    if (cmp_en) begin
      act_vec = {lvl_start, arrows, level, score, playing, game_win, game_over};
      req_vec = {(m_phase == P_LAUNCH) ? (4'b0001 << m_level) : 4'b0000, m_arrows,
                 2'(m_level), 8'(m_score), m_phase == P_PLAY, m_phase == P_WIN,
                 m_phase == P_LOSE};
      n_vec++;
      if (act_vec !== req_vec) begin
        n_err++;
        $display("FAIL outputs cyc=%0d: got %h required %h {lvl_start,arrows,level,score,play,win,over}",
                 cyc, act_vec, req_vec);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic press_start();
    start_btn = 1'b1;
    tick(1);
    start_btn = 1'b0;
    tick(1);
    chk("lvl_start on launch", int'(lvl_start), 1);
    tick(1);
    $display("start: level=%0d score=%0d playing=%0d", level, score, playing);
  endtask

  // Arrow a on level lv; press b exactly d cycles after the arrow shows on the display.
  task automatic hit(input int lv, input logic [3:0] a, input int d, input logic [3:0] b);
    lvl_arrows[4*lv +: 4] = a;
    tick(1);
    tick(d);
    btn = b;
    tick(1);
    btn = 4'b0;
    lvl_arrows[4*lv +: 4] = 4'b0;
    tick(3);
  endtask

  task automatic play_level(input int lv, input int n);
    for (int i = 0; i < n; i++) hit(lv, 4'b0001 << (i % 4), 5, 4'b0001 << (i % 4));
  endtask

  task automatic finish_level(input int lv);
    lvl_done[lv] = 1'b1;
    tick(1);
    lvl_done = '0;
    tick(2);
    $display("level %0d done: level=%0d score=%0d win=%0d over=%0d",
             lv, level, score, game_win, game_over);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(1);
    cmp_en = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    chk("reset score", int'(score), 0);
    chk("reset level", int'(level), 0);
    chk("reset playing", int'(playing), 0);

    // Game 1: level 0 with RIGHT presses, ignored foreign done, timing window edges.
    press_start();
    chk("playing after start", int'(playing), 1);
    for (int i = 0; i < 10; i++) hit(0, 4'b0100, 5, 4'b0100);
    chk("score after 10 hits", int'(score), 10);
    lvl_done[1] = 1'b1;
    tick(1);
    lvl_done = '0;
    tick(1);
    chk("foreign done ignored", int'(playing), 1);
    finish_level(0);
    chk("advance to level 1", int'(level), 1);

    hit(1, 4'b0010, HW, 4'b0010);
    chk("hit at last window cycle", int'(score), 11);
    $display("window edge press: score=%0d", score);
    hit(1, 4'b0010, HW + 1, 4'b0010);
    chk("miss past window", int'(score), 11);
    $display("late press: score=%0d", score);

    lvl_arrows[7:4] = 4'b1000;
    tick(3);
    btn = 4'b1001;
    tick(1);
    btn = 4'b0;
    tick(1);
    btn = 4'b1000;
    tick(1);
    btn = 4'b0;
    lvl_arrows[7:4] = 4'b0;
    tick(3);
    chk("two-bit press then retry", int'(score), 11);
    $display("two-bit press: score=%0d", score);

    play_level(1, 9);
    finish_level(1);
    chk("advance to level 2", int'(level), 2);
    play_level(2, 3);
    chk("score in level 2", int'(score), 23);

    // Reset mid-level with the judge armed, then a stray done.
    lvl_arrows[11:8] = 4'b1000;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    lvl_arrows = '0;
    chk("score after rst", int'(score), 0);
    chk("level after rst", int'(level), 0);
    lvl_done[2] = 1'b1;
    tick(1);
    lvl_done = '0;
    tick(2);
    chk("stray done after rst", int'(playing), 0);
    $display("mid-level reset: playing=%0d score=%0d", playing, score);

    // Game 2: level 3 falls one hit short.
    press_start();
    for (int lv = 0; lv < 3; lv++) begin
      play_level(lv, PH);
      finish_level(lv);
    end
    play_level(3, PH - 1);
    finish_level(3);
    chk("game_over", int'(game_over), 1);
    chk("arrows in LOSE", int'(arrows), 0);
    chk("score at lose", int'(score), 39);

    // Game 3: restart from LOSE, 64 hits per level saturates the score.
    press_start();
    chk("score after restart", int'(score), 0);
    for (int lv = 0; lv < NL; lv++) begin
      play_level(lv, 64);
      finish_level(lv);
    end
    chk("game_win", int'(game_win), 1);
    chk("saturated score", int'(score), 255);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
